// File: rtl/conv_bram_pkg.sv
// Shared types and constants for the ping-pong feature-map buffer.
package conv_bram_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_t;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  function automatic int unsigned byte_lanes(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/conv_bram_bank.sv
// One feature-map bank: byte-enable write port, synchronous read port,
// optional extra output register when RD_LAT is 2.
module conv_bram_bank
  import conv_bram_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned RD_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [byte_lanes(DATA_W)-1:0] we,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_din,
  input  logic                          re,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [DATA_W-1:0]             rd_dout
);

  localparam int unsigned LANES = byte_lanes(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (we[i]) mem[wr_addr][i*8 +: 8] <= wr_din[i*8 +: 8];
    end
  end

  // Held between reads so the output is stable while rd_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rd_q <= '0;
    else if (re) rd_q <= mem[rd_addr];
  end

  generate
    if (RD_LAT == 2) begin : g_oreg
      logic [DATA_W-1:0] out_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= rd_q;
      end
      assign rd_dout = out_q;
    end else begin : g_direct
      assign rd_dout = rd_q;
    end
  endgenerate

endmodule

// File: rtl/conv_fmap_pingpong_bram.sv
// Ping-pong feature-map buffer: producer fills one bank while the consumer
// drains the other; banks swap ownership through the done/ready handshake.
module conv_fmap_pingpong_bram
  import conv_bram_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned RD_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [byte_lanes(DATA_W)-1:0] wr_we,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_din,
  input  logic                          wr_done,
  output logic                          wr_ready,
  output logic                          wr_bank,
  input  logic                          rd_en,
  input  logic [ADDR_W-1:0]             rd_addr,
  input  logic                          rd_done,
  output logic                          rd_ready,
  output logic                          rd_bank,
  output logic [DATA_W-1:0]             rd_dout,
  output logic                          rd_valid,
  input  logic                          err_clr,
  output logic                          err_wr_busy,
  output logic                          err_rd_empty,
  output logic                          err_addr
);

  generate
    if (DATA_W % 8 != 0 || RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_param
      $error("conv_fmap_pingpong_bram: DATA_W must be a multiple of 8 and RD_LAT 1 or 2");
    end
  endgenerate

  bank_state_t       state [2];
  bank_state_t       state_nxt [2];
  logic              wr_sel, wr_sel_nxt;
  logic              rd_sel, rd_sel_nxt;
  logic              wr_in_range, rd_in_range;
  logic              wr_ok, rd_ok;
  logic [DATA_W-1:0] bank_dout [2];
  logic [RD_LAT-1:0] vld_pipe, sel_pipe;

  assign wr_ready    = (state[wr_sel] == EMPTY);
  assign rd_ready    = (state[rd_sel] == FULL);
  assign wr_bank     = wr_sel;
  assign rd_bank     = rd_sel;
  assign wr_in_range = (32'(wr_addr) < DEPTH);
  assign rd_in_range = (32'(rd_addr) < DEPTH);
  assign wr_ok       = wr_en && wr_ready && wr_in_range;
  assign rd_ok       = rd_en && rd_ready && rd_in_range;

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      conv_bram_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
      ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      ((wr_ok && wr_sel == 1'(b)) ? wr_we : '0),
        .wr_addr (wr_addr),
        .wr_din  (wr_din),
        .re      (rd_ok && rd_sel == 1'(b)),
        .rd_addr (rd_addr),
        .rd_dout (bank_dout[b])
      );
    end
  endgenerate

  // The write side only touches an EMPTY bank and the read side only a FULL
  // one, so both handshakes can apply in one cycle without conflict.
  always_comb begin
    state_nxt  = state;
    wr_sel_nxt = wr_sel;
    rd_sel_nxt = rd_sel;
    if (wr_done && wr_ready) begin
      state_nxt[wr_sel] = FULL;
      wr_sel_nxt        = ~wr_sel;
    end
    if (rd_done && rd_ready) begin
      state_nxt[rd_sel] = EMPTY;
      rd_sel_nxt        = ~rd_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state[0] <= EMPTY;
      state[1] <= EMPTY;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
    end else begin
      state  <= state_nxt;
      wr_sel <= wr_sel_nxt;
      rd_sel <= rd_sel_nxt;
    end
  end

  generate
    if (RD_LAT == 1) begin : g_pipe1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_pipe <= '0;
          sel_pipe <= '0;
        end else begin
          vld_pipe <= rd_ok;
          sel_pipe <= rd_sel;
        end
      end
    end else begin : g_pipe2
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_pipe <= '0;
          sel_pipe <= '0;
        end else begin
          vld_pipe <= {vld_pipe[0], rd_ok};
          sel_pipe <= {sel_pipe[0], rd_sel};
        end
      end
    end
  endgenerate

  assign rd_valid = vld_pipe[RD_LAT-1];
  assign rd_dout  = bank_dout[sel_pipe[RD_LAT-1]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_wr_busy  <= 1'b0;
      err_rd_empty <= 1'b0;
      err_addr     <= 1'b0;
    end else begin
      err_wr_busy  <= (err_wr_busy  && !err_clr) || (wr_en && !wr_ready);
      err_rd_empty <= (err_rd_empty && !err_clr) || (rd_en && !rd_ready);
      err_addr     <= (err_addr     && !err_clr)
                    || (wr_en && wr_ready && !wr_in_range)
                    || (rd_en && rd_ready && !rd_in_range);
    end
  end

endmodule

// File: doc/conv_fmap_pingpong_bram.md
# conv_fmap_pingpong_bram

Parametrised ping-pong feature-map buffer for the CNN accelerator engine: two byte-writable banks, one owned by the producer (convolution output writer) and one by the consumer (next-stage reader), swapped by a done/ready handshake. It replaces the fixed-size per-layer dual-port BRAM instances. Width, depth and read latency are parametric, and the block detects writes to a busy bank and out-of-range addresses.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8
- DEPTH, 1024, words per bank; need not be a power of two
- ADDR_W, $clog2(DEPTH), address width
- RD_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register)

- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- wr_we  in  DATA_W/8  byte enables; bit i covers din[8i+7:8i]
- wr_addr  in  ADDR_W  write word address
- wr_din  in  DATA_W  write data
- wr_done  in  1  producer has finished filling the current write bank
- wr_ready  out  1  current write bank is EMPTY and may be written
- wr_bank  out  1  index of the current write bank
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read word address
- rd_done  in  1  consumer has finished with the current read bank
- rd_ready  out  1  current read bank is FULL and may be read
- rd_bank  out  1  index of the current read bank
- rd_dout  out  DATA_W  read data
- rd_valid  out  1  rd_dout valid this cycle
- err_clr  in  1  clears all sticky error flags
- err_wr_busy  out  1  sticky: wr_en seen while wr_ready=0
- err_rd_empty  out  1  sticky: rd_en seen while rd_ready=0
- err_addr  out  1  sticky: accepted request with address >= DEPTH

## Operation
- Each bank has a 1-bit state, EMPTY or FULL. A write pointer wr_sel and a read pointer rd_sel select the banks.
- wr_ready = (state[wr_sel]==EMPTY). rd_ready = (state[rd_sel]==FULL).
- Write: if wr_en && wr_ready && wr_addr<DEPTH, write each enabled byte of bank[wr_sel] at wr_addr. Disabled bytes are untouched.
- wr_done && wr_ready: set state[wr_sel] to FULL and toggle wr_sel. wr_done while wr_ready=0 is ignored and raises no error.
- Read: if rd_en && rd_ready && rd_addr<DEPTH, read bank[rd_sel] at rd_addr. rd_valid follows after RD_LAT cycles.
- rd_done && rd_ready: set state[rd_sel] to EMPTY and toggle rd_sel.
- wr_done and rd_done may be asserted in the same cycle; both apply. They can never target one bank in conflicting ways, because the write side requires EMPTY and the read side requires FULL.
- A write and rd_done in the same cycle are legal.
- Rejected requests:
  - Busy or empty bank: no memory access, no rd_valid; set err_wr_busy or err_rd_empty.
  - Out-of-range address: no memory access, no rd_valid; set err_addr.
- Error flags: err_clr clears them. A new error in the same cycle as err_clr wins, so the flag stays set.
- Read data is the bank content at the sample edge. Write and read never target the same bank in the same cycle, so no collision policy is needed.

## Timing
- Reset values: wr_sel=0, rd_sel=0, both banks EMPTY, wr_ready=1, rd_ready=0, wr_bank=0, rd_bank=0, rd_valid=0, rd_dout=0, all error flags 0. Memory contents are not reset.
- Write: data is in the array at the clk edge where wr_en is sampled.
- State handshake: wr_done or rd_done sampled at edge N changes bank states and pointers after edge N. wr_ready, rd_ready and the bank outputs update combinationally from the new registers in cycle N+1.
- Minimum bank handoff: the last write at edge N with wr_done also at N gives rd_ready=1 in cycle N+1.
- Read, RD_LAT=1: rd_en at edge N gives rd_valid and rd_dout in cycle N+1.
- Read, RD_LAT=2: rd_en at edge N gives rd_valid and rd_dout in cycle N+2.
- Back-to-back reads give one word per cycle.
- A read issued before rd_done still completes after the bank is released.
- Reset asserted mid-operation: all registers return to reset values at once, and in-flight reads are discarded (rd_valid=0).

## Structure
- Package conv_bram_pkg holds:
  - bank_state_t enum {EMPTY, FULL}
  - RD_LAT_MIN=1 and RD_LAT_MAX=2 constants
  - a function computing byte lanes from DATA_W
- Sub-module conv_bram_bank: a simple dual-port memory with byte-enable write port, synchronous read port and an optional output register set by RD_LAT. It is instantiated twice.
- The top level holds the pointers, bank states, muxing, the rd_valid shift pipeline and the error logic.
- An elaboration-time check rejects DATA_W%8!=0 and RD_LAT outside 1..2.

## Test plan
- Reset, then write addr 0..3 with 0xA0..0xA3 and wr_we=4'hF, then pulse wr_done → rd_ready=1 and rd_bank=0. Reads of 0..3 return 0xA0..0xA3 one cycle later (RD_LAT=1) and two cycles later (RD_LAT=2).
- Write 0x11223344 to addr 5, then write 0xFFFFFFFF to addr 5 with wr_we=4'b0101 → reading addr 5 returns 0x11FF33FF.
- Fill bank 0 and wr_done, fill bank 1 and wr_done → wr_ready=0. A further wr_en sets err_wr_busy with memory unchanged. rd_done then gives wr_ready=1 and wr_bank=0.
- Assert wr_done and rd_done in the same cycle with both pointers valid → both bank states update and both pointers toggle.
- DEPTH=1000: write to addr 1000 → err_addr=1 and no memory change. err_clr clears it. rd_en with rd_ready=0 → err_rd_empty=1 and rd_valid stays 0.
- Issue rd_en, then assert rst_n=0 asynchronously on the next cycle → rd_valid=0, wr_ready=1, rd_ready=0 and both pointers return to 0.
